// File: rtl/bpu.sv
// Branch prediction unit: fully associative branch table with a same-cycle
// fetch lookup and a registered allocate/train port driven by execute.
`default_nettype none

// ============================================================================
//  Module   : bpu
//  Purpose  : fully associative branch target table, 2-bit saturating counters
//  Revision : 1.0  initial release
// ============================================================================
module bpu #(
    parameter int ENTRIES = 32,
    parameter int ADDR_W  = 5,
    parameter int TAG_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if2bp_valid,
    input  logic [31:0]       if2bp_pc,
    output logic              bp2if_match,
    output logic              bp2if_taken,
    output logic [ADDR_W-1:0] bp2if_addr,
    output logic [31:0]       bp2if_target,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic              flush_valid,
    input  logic              flush_new_pc,
    input  logic              flush_type,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic [31:0]       flush_bp_pc,
    input  logic [31:0]       flush_pc
);

    logic [ENTRIES-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [31:0]        tgt_d [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [1:0]         ctr_d [ENTRIES];
    logic [ADDR_W-1:0]  vp_q, vp_d;

    logic               lk_hit;
    logic [ADDR_W-1:0]  lk_idx;
    logic               al_hit;
    logic [ADDR_W-1:0]  al_idx;
    logic               upd;
    logic               trn_en;
    logic [ADDR_W-1:0]  trn_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [TAG_W-1:0]   fl_tag;

    assign lk_tag = if2bp_pc[TAG_W-1:0];
    assign fl_tag = flush_bp_pc[TAG_W-1:0];
    assign upd    = flush_valid && ex_valid && !ex_stall;

    generate
        if (TAG_W < 32) begin : g_unused
            logic unused_pc_bits;
            assign unused_pc_bits = ^{if2bp_pc[31:TAG_W], flush_bp_pc[31:TAG_W]};
        end
    endgenerate

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Two CAM ports; scanning downward leaves the lowest matching index.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        al_hit = 1'b0;
        al_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (vld_q[i] && (tag_q[i] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_idx = i[ADDR_W-1:0];
            end
            if (vld_q[i] && (tag_q[i] == fl_tag)) begin
                al_hit = 1'b1;
                al_idx = i[ADDR_W-1:0];
            end
        end
    end

    assign bp2if_match  = if2bp_valid && lk_hit;
    assign bp2if_taken  = bp2if_match && ctr_q[lk_idx][1];
    assign bp2if_addr   = lk_hit ? lk_idx : vp_q;
    assign bp2if_target = bp2if_match ? tgt_q[lk_idx] : 32'h0;

    always_comb begin
        vld_d   = vld_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        vp_d    = vp_q;
        trn_en  = 1'b0;
        trn_idx = flush_addr;
        if (upd) begin
            if (flush_new_pc) begin
                // A second miss of an already-allocated branch trains it instead.
                if (al_hit) begin
                    trn_en  = 1'b1;
                    trn_idx = al_idx;
                end else begin
                    vld_d[vp_q] = 1'b1;
                    tag_d[vp_q] = fl_tag;
                    tgt_d[vp_q] = flush_pc;
                    ctr_d[vp_q] = flush_type ? 2'b10 : 2'b01;
                    vp_d        = vp_q + 1'b1;
                end
            end else if (vld_q[flush_addr] && (tag_q[flush_addr] == fl_tag)) begin
                trn_en = 1'b1;
            end
        end
        if (trn_en) begin
            ctr_d[trn_idx] = ctr_next(ctr_q[trn_idx], flush_type);
            tgt_d[trn_idx] = flush_pc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            vp_q  <= '0;
        end else begin
            vld_q <= vld_d;
            vp_q  <= vp_d;
        end
    end

    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    tag_q[g] <= '0;
                    tgt_q[g] <= '0;
                    ctr_q[g] <= 2'b01;
                end else begin
                    tag_q[g] <= tag_d[g];
                    tgt_q[g] <= tgt_d[g];
                    ctr_q[g] <= ctr_d[g];
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bpu.sv
// Self-checking bench for bpu: directed scenarios then random traffic, all
// compared against an entry-list reference model.
`default_nettype none

module tb_bpu;

    logic        clk;
    logic        rstn;
    logic        if2bp_valid;
    logic [31:0] if2bp_pc;
    logic        bp2if_match;
    logic        bp2if_taken;
    logic [4:0]  bp2if_addr;
    logic [31:0] bp2if_target;
    logic        ex_valid;
    logic        ex_stall;
    logic        flush_valid;
    logic        flush_new_pc;
    logic        flush_type;
    logic [4:0]  flush_addr;
    logic [31:0] flush_bp_pc;
    logic [31:0] flush_pc;

    int n_pass  = 0;
    int n_total = 0;

    bpu #(.ENTRIES(32), .ADDR_W(5), .TAG_W(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .if2bp_valid  (if2bp_valid),
        .if2bp_pc     (if2bp_pc),
        .bp2if_match  (bp2if_match),
        .bp2if_taken  (bp2if_taken),
        .bp2if_addr   (bp2if_addr),
        .bp2if_target (bp2if_target),
        .ex_valid     (ex_valid),
        .ex_stall     (ex_stall),
        .flush_valid  (flush_valid),
        .flush_new_pc (flush_new_pc),
        .flush_type   (flush_type),
        .flush_addr   (flush_addr),
        .flush_bp_pc  (flush_bp_pc),
        .flush_pc     (flush_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one record per table slot, counters as plain integers.
    bit          m_vld [32];
    logic [15:0] m_tag [32];
    logic [31:0] m_tgt [32];
    int          m_ctr [32];
    int          m_vp;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_vld[i] = 0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
            m_ctr[i] = 1;
        end
        m_vp = 0;
    endfunction

    function automatic int model_find(input logic [15:0] t);
        for (int i = 0; i < 32; i++)
            if (m_vld[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic logic [38:0] model_lookup(input logic v, input logic [31:0] pc);
        int          idx;
        logic        m;
        logic        t;
        logic [4:0]  a;
        logic [31:0] tg;
        idx = model_find(pc[15:0]);
        m   = v && (idx >= 0);
        t   = 1'b0;
        tg  = 32'h0;
        a   = m_vp[4:0];
        if (idx >= 0) a = idx[4:0];
        if (m) begin
            t  = (m_ctr[idx] >= 2);
            tg = m_tgt[idx];
        end
        return {m, t, a, tg};
    endfunction

    function automatic void model_train(input int idx);
        m_ctr[idx] = flush_type ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        m_tgt[idx] = flush_pc;
    endfunction

    function automatic void model_update();
        int idx;
        if (!(flush_valid && ex_valid && !ex_stall)) return;
        if (flush_new_pc) begin
            idx = model_find(flush_bp_pc[15:0]);
            if (idx >= 0) begin
                model_train(idx);
            end else begin
                m_vld[m_vp] = 1;
                m_tag[m_vp] = flush_bp_pc[15:0];
                m_tgt[m_vp] = flush_pc;
                m_ctr[m_vp] = flush_type ? 2 : 1;
                m_vp        = (m_vp + 1) % 32;
            end
        end else if (m_vld[flush_addr] && m_tag[flush_addr] == flush_bp_pc[15:0]) begin
            model_train(int'(flush_addr));
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [38:0] dut_out();
        return {bp2if_match, bp2if_taken, bp2if_addr, bp2if_target};
    endfunction

    // One clock: compare mid-cycle, then advance the model with the edge.
    task automatic step(input string name, input logic lit, input logic [38:0] exp_lit);
        @(negedge clk);
        check({name, ".model"}, 64'(dut_out()), 64'(model_lookup(if2bp_valid, if2bp_pc)));
        if (lit) check(name, 64'(dut_out()), 64'(exp_lit));
        @(posedge clk);
        if (rstn) model_update();
        #1;
    endtask

    task automatic set_look(input logic v, input logic [31:0] pc);
        if2bp_valid = v;
        if2bp_pc    = pc;
    endtask

    task automatic set_flush(input logic fv, input logic ev, input logic st, input logic np,
                             input logic ty, input logic [4:0] fa, input logic [31:0] bp,
                             input logic [31:0] fp);
        flush_valid  = fv;
        ex_valid     = ev;
        ex_stall     = st;
        flush_new_pc = np;
        flush_type   = ty;
        flush_addr   = fa;
        flush_bp_pc  = bp;
        flush_pc     = fp;
    endtask

    task automatic clr_flush();
        set_flush(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic alloc(input logic [31:0] bp, input logic ty, input logic [31:0] fp);
        set_look(0, 32'h0);
        set_flush(1, 1, 0, 1, ty, 5'd0, bp, fp);
        step("alloc", 0, '0);
        clr_flush();
    endtask

    task automatic train(input logic [4:0] a, input logic [31:0] bp, input logic ty,
                         input logic [31:0] fp);
        set_look(0, 32'h0);
        set_flush(1, 1, 0, 0, ty, a, bp, fp);
        step("train", 0, '0);
        clr_flush();
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic em,
                        input logic et, input logic [4:0] ea, input logic [31:0] etg);
        set_look(1, pc);
        clr_flush();
        step(name, 1, {em, et, ea, etg});
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        logic [31:0] pc;
        rstn = 1'b0;
        model_reset();
        set_look(1, 32'h100);
        clr_flush();
        @(negedge clk);
        check("in_reset", 64'(dut_out()), 64'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        look("reset_lookup", 32'h100, 0, 0, 5'd0, 32'h0);
        alloc(32'h100, 1, 32'h140);
        look("alloc_hit", 32'h100, 1, 1, 5'd0, 32'h140);
        look("alloc_miss", 32'h200, 0, 0, 5'd1, 32'h0);

        for (int k = 0; k < 3; k++) begin
            train(5'd0, 32'h100, 0, 32'h140);
            look("nt_train", 32'h100, 1, 0, 5'd0, 32'h140);
        end
        train(5'd0, 32'h100, 1, 32'h140);
        look("t_train_01", 32'h100, 1, 0, 5'd0, 32'h140);
        for (int k = 0; k < 3; k++) begin
            train(5'd0, 32'h100, 1, 32'h140);
            look("t_train_hi", 32'h100, 1, 1, 5'd0, 32'h140);
        end
        train(5'd0, 32'h100, 0, 32'h150);
        look("sat_hi_nt", 32'h100, 1, 1, 5'd0, 32'h150);

        do_reset();
        for (int k = 0; k < 33; k++)
            alloc(32'h100 + 32'(4 * k), 0, 32'h8000 + 32'(k));
        look("wrap_evicted", 32'h100, 0, 0, 5'd1, 32'h0);
        look("wrap_entry0", 32'h180, 1, 0, 5'd0, 32'h8020);
        look("wrap_entry1", 32'h104, 1, 0, 5'd1, 32'h8001);

        alloc(32'h300, 1, 32'h3000);
        alloc(32'h300, 1, 32'h3000);
        look("dup_hit", 32'h300, 1, 1, 5'd1, 32'h3000);
        look("dup_vp", 32'h999, 0, 0, 5'd2, 32'h0);
        train(5'd1, 32'h104, 0, 32'hdead);
        look("stale_train", 32'h300, 1, 1, 5'd1, 32'h3000);

        set_look(0, 32'h0);
        set_flush(1, 1, 1, 1, 1, 5'd0, 32'h400, 32'h4000);
        step("gate_stall", 0, '0);
        set_flush(1, 0, 0, 1, 1, 5'd0, 32'h400, 32'h4000);
        step("gate_exv", 0, '0);
        set_flush(1, 1, 1, 0, 1, 5'd0, 32'h180, 32'h4444);
        step("gate_train", 0, '0);
        look("gate_alloc", 32'h400, 0, 0, 5'd2, 32'h0);
        look("gate_tr", 32'h180, 1, 0, 5'd0, 32'h8020);

        set_look(1, 32'h180);
        set_flush(1, 1, 0, 0, 1, 5'd0, 32'h180, 32'h5000);
        step("same_cycle_old", 1, {1'b1, 1'b0, 5'd0, 32'h8020});
        look("same_cycle_new", 32'h180, 1, 1, 5'd0, 32'h5000);

        set_look(1, 32'h180);
        set_flush(1, 1, 0, 1, 1, 5'd0, 32'h600, 32'h6000);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_reset", 64'(dut_out()), 64'h0);
        @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;
        look("post_reset_a", 32'h180, 0, 0, 5'd0, 32'h0);
        look("post_reset_b", 32'h600, 0, 0, 5'd0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            pc = 32'h1000 + 32'(4 * $urandom_range(0, 39));
            set_look($urandom_range(0, 7) != 0, pc | (32'($urandom_range(0, 3)) << 16));
            pc = 32'h1000 + 32'(4 * $urandom_range(0, 39));
            idx = model_find(pc[15:0]);
            set_flush($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1,
                      (idx >= 0 && $urandom_range(0, 1) == 1) ? idx[4:0] : 5'($urandom_range(0, 31)),
                      pc, $urandom);
            step("random", 0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bpu.md
# bpu

Branch prediction unit serving the fetch stage and trained by the execute stage. Holds a fully associative table of branch entries: PC tag, target and 2-bit saturating counter. Fetch gets a same-cycle lookup result: taken, match, entry address and target. Fetch carries these down the pipe as `bp_taken`, `bp_match` and `bp_addr`. The execute stage returns resolution through the `flush_*` update port, and the unit allocates or trains an entry.

## Interface
- `ENTRIES`, default 32: number of table entries; must be a power of 2.
- `ADDR_W`, default 5: log2(`ENTRIES`); equals the pipeline `BP_ADDR_W`.
- `TAG_W`, default 16: PC bits stored as tag; equals the width exu truncates `flush_bp_pc` to (`BP_ADDR_BITS`).
- Ports:
  - `clk` in 1: clock.
  - `rstn` in 1: reset, asynchronous, active-low.
  - `if2bp_valid` in 1: lookup request valid.
  - `if2bp_pc` in 32: fetch PC to look up.
  - `bp2if_match` out 1: lookup hit on a valid entry.
  - `bp2if_taken` out 1: predict taken.
  - `bp2if_addr` out `ADDR_W`: hit index, or current victim pointer on a miss.
  - `bp2if_target` out 32: predicted target of the hit entry, else 0.
  - `ex_valid` in 1: execute stage holds a valid, unflushed instruction.
  - `ex_stall` in 1: execute stage stalled; update suppressed.
  - `flush_valid` in 1: execute stage holds a branch.
  - `flush_new_pc` in 1: branch was not in the table at lookup; allocate.
  - `flush_type` in 1: 1 = resolved taken, 0 = not taken.
  - `flush_addr` in `ADDR_W`: entry index from lookup; used only when `flush_new_pc`=0.
  - `flush_bp_pc` in 32: branch PC, zero-extended; low `TAG_W` bits are the tag.
  - `flush_pc` in 32: branch target (pc+imm).

## Operation
- Per-entry state: `vld`, `tag[TAG_W]`, `tgt[32]`, `ctr[2]`.
  - `ctr` encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Global state: victim pointer `vp[ADDR_W]`, round-robin.
- Lookup (combinational):
  - `hit` = some entry has `vld` && `tag == if2bp_pc[TAG_W-1:0]`; the lowest index wins if several match.
  - `bp2if_match = if2bp_valid && hit`.
  - `bp2if_taken = bp2if_match && ctr[1]`.
  - `bp2if_addr` = hit index if `hit`, else `vp`.
  - `bp2if_target` = `tgt` of the hit entry if `bp2if_match`, else 0.
- Update enable: `upd = flush_valid && ex_valid && !ex_stall`.
- Allocate (`upd && flush_new_pc`):
  - Searches the table for `flush_bp_pc[TAG_W-1:0]` (second CAM port).
  - If found, e.g. two in-flight misses of the same branch: train that entry as below; `vp` unchanged.
  - Otherwise write entry `vp`: `vld`=1, `tag`, `tgt=flush_pc`, `ctr = flush_type ? 10 : 01`.
  - Then `vp <= vp+1`, wrapping `ENTRIES-1 -> 0`.
  - `flush_addr` is ignored on allocation.
- Train (`upd && !flush_new_pc`), applied to entry `flush_addr`:
  - `flush_type`=1: `ctr` increments, saturating at 11.
  - `flush_type`=0: `ctr` decrements, saturating at 00.
  - `tgt <= flush_pc`.
  - If that entry is invalid, or its tag differs (it was replaced since lookup), no write occurs.
- All writes happen on `posedge clk`. There is no bypass: a lookup in the same cycle as an update to the same entry returns the pre-update state.

## Timing
- Reset (async, `rstn`=0):
  - Every `vld`=0, `ctr`=01, `tgt`=0, `tag`=0; `vp`=0.
  - Outputs during and after reset: `match`=0, `taken`=0, `addr`=0, `target`=0.
- Lookup latency 0: outputs are a pure function of `if2bp_*` and table state.
- Update latency 1: the result is visible to a lookup in the cycle after `upd`.
- At most one update per cycle; no handshake, no back-pressure.
- If reset asserts mid-update, the write is lost and the table clears.

## Test plan
- Reset, then lookup `pc`=0x100 -> `match`=0, `taken`=0, `addr`=0, `target`=0.
- Allocate with `upd`, `new_pc`=1, `type`=1, `bp_pc`=0x100, `flush_pc`=0x140. Next-cycle lookup of 0x100 -> `match`=1, `taken`=1, `addr`=0, `target`=0x140. Lookup of 0x200 -> `match`=0, `addr`=1.
- Saturation: from `ctr`=10 on entry 0, apply three not-taken trains (`flush_addr`=0).
  - `ctr` goes 01, 00, 00; `taken`=0 after the first.
  - Four taken trains then give `ctr` 01, 10, 11, 11.
- Wrap: allocate 33 distinct PCs 0x100, 0x104, … -> the 33rd lands in entry 0, `vp`=1, and a lookup of 0x100 misses.
- Duplicate and stale cases:
  - Two back-to-back `new_pc` allocations of 0x300 -> one entry, `vp` advanced once.
  - A train to an entry retagged since lookup -> no change.
- Gating: `flush_valid`=1 with `ex_stall`=1, or with `ex_valid`=0 -> table unchanged.
- Same-cycle update and lookup of 0x100 -> lookup returns the old `ctr` and `tgt`; the new values appear the next cycle.
